// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data memory arbiter.
// Imported by the arbiter top and its round-robin picker.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic [1:0] WORD_ALIGN = 2'b00;

  // The requester that gets priority after `id` has been served.
  function automatic logic other_id(input logic id);
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
// The priority pointer is owned by the caller.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  // A lone request wins; a tie goes to the pointer.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = REQ0;
    unique case (req_i)
      2'b01: begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = REQ0;
      end
      2'b10: begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = REQ1;
      end
      2'b11: begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = prio_i;
      end
      default: begin
        gnt_valid_o = 1'b0;
        gnt_id_o    = REQ0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-master req/ack sequencer for the data memory.
// IDLE picks a winner, ACCESS drives the memory, DONE returns the ack.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_LIMIT = 1048576
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,

  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Highest byte address at which a full word still fits.
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(ADDR_LIMIT - 4);

  state_e state_q, state_d;

  logic prio_q, prio_d;
  logic id_q, id_d;
  logic we_q, we_d;
  logic err_q, err_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              gnt_valid;
  logic              gnt_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;

  logic in_access;
  logic in_done;
  logic mem_en;

  rr_arb2 u_arb (
    .req_i       ({r1_req, r0_req}),
    .prio_i      (prio_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // Steer the winner's fields and classify the access.
  always_comb begin
    sel_we    = r0_we;
    sel_addr  = r0_addr;
    sel_wdata = r0_wdata;
    if (gnt_id == REQ1) begin
      sel_we    = r1_we;
      sel_addr  = r1_addr;
      sel_wdata = r1_wdata;
    end
    sel_err = (sel_addr[1:0] != WORD_ALIGN)
            || (sel_addr > LAST_WORD);
  end

  // Next-state logic for the IDLE/ACCESS/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    id_d        = id_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          id_d        = gnt_id;
          we_d        = sel_we;
          err_d       = sel_err;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          prio_d      = other_id(gnt_id);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // Reads capture memory data; rejected accesses return zero.
        if (err_q || !we_q) begin
          if (id_q == REQ1) begin
            rdata1_d = err_q ? '0 : mem_rdata;
          end else begin
            rdata0_d = err_q ? '0 : mem_rdata;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= REQ0;
      id_q        <= REQ0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      id_q        <= id_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign in_access = (state_q == ACCESS);
  assign in_done   = (state_q == DONE);

  // Enables are gated by rst so a write racing reset is not committed.
  assign mem_en    = in_access & ~err_q & ~rst;
  assign mem_read  = mem_en & ~we_q;
  assign mem_write = mem_en &  we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign r0_ack   = in_done & (id_q == REQ0);
  assign r1_ack   = in_done & (id_q == REQ1);
  assign r0_err   = r0_ack & err_q;
  assign r1_err   = r1_ack & err_q;
  assign r0_rdata = rdata0_q;
  assign r1_rdata = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and randomized checks of data_mem_arbiter.
// A transaction-level model tracks memory contents and grant order.
module tb_data_mem_arbiter;

  localparam logic [31:0] LIM = 32'd1048576;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r0_ack, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_ack, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  logic        mem_init;
  logic [31:0] mem [0:255];
  logic [31:0] mm [0:255];
  logic [31:0] last_rd [0:1];
  bit          ptr;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .r1_err(r1_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] fill(input int i);
    return 32'hC0DE0000 + 32'(i);
  endfunction

  // Small memory: low 1 KiB window, combinational read.
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= fill(i);
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  function automatic bit is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > LIM - 32'd4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input bit rq, input bit we,
                       input logic [31:0] a, input logic [31:0] wd);
    if (id) begin
      r1_req = rq; r1_we = we; r1_addr = a; r1_wdata = wd;
    end else begin
      r0_req = rq; r0_we = we; r0_addr = a; r0_wdata = wd;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    ptr = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  // One solo transaction; returns what was observed along the way.
  task automatic run_one(input bit id, input bit we,
                         input logic [31:0] a, input logic [31:0] wd,
                         output bit mr, output bit mw, output bit ack,
                         output bit err, output logic [31:0] rd);
    drive(id, 1, we, a, wd);
    tick();
    mr = mem_read;
    mw = mem_write;
    tick();
    ack = id ? r1_ack : r0_ack;
    err = id ? r1_err : r0_err;
    rd  = id ? r1_rdata : r0_rdata;
    drive(id, 0, we, a, wd);
    tick();
  endtask

  task automatic test_reset();
    mem_init = 1'b1;
    rst = 1'b1;
    drive(0, 1, 1, 32'h10, 32'h1);
    drive(1, 0, 0, 0, 0);
    tick();
    tick();
    mem_init = 1'b0;
    for (int i = 0; i < 256; i++) mm[i] = fill(i);
    n_chk++;
    if ({r0_ack, r0_err, r1_ack, r1_err, mem_read, mem_write} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {r0_ack, r0_err, r1_ack, r1_err, mem_read, mem_write});
    end
    n_chk++;
    if ({r0_rdata, r1_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      n_fail++;
      $display("FAIL reset_data got=%h %h %h %h want=0",
               r0_rdata, r1_rdata, mem_addr, mem_wdata);
    end
    do_reset();
  endtask

  task automatic test_write_read();
    drive(0, 1, 1, 32'h10, 32'hDEADBEEF);
    tick();
    n_chk++;
    if ({mem_write, mem_read, mem_addr, mem_wdata} !==
        {2'b10, 32'h10, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL wr_access got=%b%b %h %h want=10 10 deadbeef",
               mem_write, mem_read, mem_addr, mem_wdata);
    end
    tick();
    n_chk++;
    if ({r0_ack, r0_err, r1_ack} !== 3'b100) begin
      n_fail++;
      $display("FAIL wr_ack got=%b want=100", {r0_ack, r0_err, r1_ack});
    end
    drive(0, 0, 0, 0, 0);
    mm[4] = 32'hDEADBEEF;
    tick();
    n_chk++;
    if (r0_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_ack_pulse got=%b want=0", r0_ack);
    end
    drive(0, 1, 0, 32'h10, 32'h0);
    tick();
    n_chk++;
    if ({mem_read, mem_write} !== 2'b10) begin
      n_fail++;
      $display("FAIL rd_access got=%b want=10", {mem_read, mem_write});
    end
    tick();
    n_chk++;
    if ({r0_ack, r0_err, r0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL rd_ack got=%b%b %h want=10 deadbeef",
               r0_ack, r0_err, r0_rdata);
    end
    drive(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_ack;
    do_reset();
    drive(0, 1, 0, 32'h10, 32'h0);
    drive(1, 1, 0, 32'h14, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_ack = 2'b00;
      if (c % 3 == 2) exp_ack = ((c / 3) % 2 == 1) ? 2'b10 : 2'b01;
      n_chk++;
      if ({r1_ack, r0_ack} !== exp_ack) begin
        n_fail++;
        $display("FAIL contend_ack c=%0d got=%b want=%b",
                 c, {r1_ack, r0_ack}, exp_ack);
      end
      if (exp_ack == 2'b01) begin
        n_chk++;
        if (r0_rdata !== mm[4]) begin
          n_fail++;
          $display("FAIL contend_rd0 got=%h want=%h", r0_rdata, mm[4]);
        end
      end
      if (exp_ack == 2'b10) begin
        n_chk++;
        if (r1_rdata !== mm[5]) begin
          n_fail++;
          $display("FAIL contend_rd1 got=%h want=%h", r1_rdata, mm[5]);
        end
      end
      if (c == 11) begin
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
      end
    end
  endtask

  task automatic test_misaligned();
    bit mr, mw, ack, err;
    logic [31:0] rd;
    run_one(1, 1, 32'h13, 32'hBAD0BAD0, mr, mw, ack, err, rd);
    n_chk++;
    if ({mr, mw, ack, err, rd} !== {4'b0011, 32'h0}) begin
      n_fail++;
      $display("FAIL misalign got=%b%b%b%b %h want=0011 0",
               mr, mw, ack, err, rd);
    end
    run_one(0, 0, 32'h10, 32'h0, mr, mw, ack, err, rd);
    n_chk++;
    if ({ack, err, rd} !== {2'b10, mm[4]}) begin
      n_fail++;
      $display("FAIL misalign_keep got=%b%b %h want=10 %h",
               ack, err, rd, mm[4]);
    end
  endtask

  task automatic test_out_of_range();
    bit mr, mw, ack, err;
    logic [31:0] rd;
    logic [31:0] addrs [0:3];
    bit          want [0:3];
    addrs[0] = LIM - 32'd4;  want[0] = 1'b0;
    addrs[1] = LIM - 32'd2;  want[1] = 1'b1;
    addrs[2] = LIM;          want[2] = 1'b1;
    addrs[3] = 32'hFFFFFFFC; want[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_one(0, 0, addrs[i], 32'h0, mr, mw, ack, err, rd);
      n_chk++;
      if ({ack, err, mr} !== {1'b1, want[i], ~want[i]}) begin
        n_fail++;
        $display("FAIL range a=%h got=%b%b%b want=1%b%b",
                 addrs[i], ack, err, mr, want[i], ~want[i]);
      end
      if (want[i]) begin
        n_chk++;
        if (rd !== 32'h0) begin
          n_fail++;
          $display("FAIL range_rd a=%h got=%h want=0", addrs[i], rd);
        end
      end
    end
  endtask

  task automatic test_reset_access();
    bit mr, mw, ack, err;
    logic [31:0] rd;
    drive(0, 1, 1, 32'h20, 32'h12345678);
    tick();
    rst = 1'b1;
    #1;
    n_chk++;
    if ({mem_write, mem_read} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_gate got=%b want=00", {mem_write, mem_read});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    n_chk++;
    if ({r0_ack, r0_err, r1_ack, r1_err, mem_read, mem_write,
         r0_rdata, r1_rdata, mem_addr, mem_wdata} !== 134'b0) begin
      n_fail++;
      $display("FAIL rst_outs got=%b%b %h %h %h %h want=0",
               r0_ack, r1_ack, r0_rdata, r1_rdata, mem_addr, mem_wdata);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if ({r0_ack, r1_ack} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_noack c=%0d got=%b want=00",
                 c, {r0_ack, r1_ack});
      end
    end
    run_one(0, 0, 32'h20, 32'h0, mr, mw, ack, err, rd);
    n_chk++;
    if ({ack, err, rd} !== {2'b10, mm[8]}) begin
      n_fail++;
      $display("FAIL rst_nocommit got=%b%b %h want=10 %h",
               ack, err, rd, mm[8]);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ack;
    do_reset();
    drive(1, 1, 0, 32'h14, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp_ack = (c == 2 || c == 5) ? 2'b10 : 2'b00;
      n_chk++;
      if ({r1_ack, r0_ack} !== exp_ack) begin
        n_fail++;
        $display("FAIL b2b_hold c=%0d got=%b want=%b",
                 c, {r1_ack, r0_ack}, exp_ack);
      end
      if (c == 5) drive(1, 0, 0, 0, 0);
    end
    do_reset();
    drive(1, 1, 1, 32'h18, 32'hA1B2C3D4);
    for (int c = 1; c <= 9; c++) begin
      tick();
      exp_ack = 2'b00;
      if (c == 2 || c == 8) exp_ack = 2'b10;
      if (c == 5) exp_ack = 2'b01;
      n_chk++;
      if ({r1_ack, r0_ack} !== exp_ack) begin
        n_fail++;
        $display("FAIL b2b_steal c=%0d got=%b want=%b",
                 c, {r1_ack, r0_ack}, exp_ack);
      end
      if (c == 2) begin
        mm[6] = 32'hA1B2C3D4;
        drive(0, 1, 0, 32'h18, 32'h0);
      end
      if (c == 5) begin
        n_chk++;
        if (r0_rdata !== mm[6]) begin
          n_fail++;
          $display("FAIL b2b_rd got=%h want=%h", r0_rdata, mm[6]);
        end
        drive(0, 0, 0, 0, 0);
      end
      if (c == 8) drive(1, 0, 0, 0, 0);
    end
  endtask

  task automatic test_random();
    bit          we_a [0:1];
    logic [31:0] ad_a [0:1];
    logic [31:0] wd_a [0:1];
    bit          order [0:1];
    bit          id;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          nexp, k, pat, kind;
    do_reset();
    for (int r = 0; r < 60; r++) begin
      pat = $urandom_range(1, 3);
      for (int j = 0; j < 2; j++) begin
        we_a[j] = 1'($urandom_range(0, 1));
        wd_a[j] = $urandom;
        kind = $urandom_range(0, 9);
        if (kind == 0)
          ad_a[j] = 32'($urandom_range(0, 255)) * 4
                  + 32'($urandom_range(1, 3));
        else if (kind == 1)
          ad_a[j] = LIM - 32'd2 + 32'($urandom_range(0, 6)) * 2;
        else
          ad_a[j] = 32'($urandom_range(0, 15)) * 4;
      end
      if (pat == 3) begin
        order[0] = ptr; order[1] = ~ptr; nexp = 2;
      end else begin
        order[0] = (pat == 2); nexp = 1;
      end
      for (int j = 0; j < 2; j++)
        if (pat[j]) drive(j[0], 1, we_a[j], ad_a[j], wd_a[j]);
      k = 0;
      for (int c = 1; c <= 12 && k < nexp; c++) begin
        tick();
        if (c == 2 + 3 * k) begin
          id = order[k];
          exp_err = is_bad(ad_a[id]);
          if (exp_err) exp_rd = '0;
          else if (we_a[id]) begin
            mm[ad_a[id][9:2]] = wd_a[id];
            exp_rd = last_rd[id];
          end else exp_rd = mm[ad_a[id][9:2]];
          last_rd[id] = exp_rd;
          ptr = ~id;
          n_chk++;
          if ({r1_ack, r0_ack} !== (2'b01 << id)) begin
            n_fail++;
            $display("FAIL rand_ack r=%0d got=%b want=%b",
                     r, {r1_ack, r0_ack}, 2'b01 << id);
          end
          n_chk++;
          if ((id ? {r1_err, r1_rdata} : {r0_err, r0_rdata})
              !== {exp_err, exp_rd}) begin
            n_fail++;
            $display("FAIL rand_data r=%0d id=%0d a=%h got=%b %h want=%b %h",
                     r, id, ad_a[id], id ? r1_err : r0_err,
                     id ? r1_rdata : r0_rdata, exp_err, exp_rd);
          end
          drive(id, 0, 0, 0, 0);
          k++;
        end else begin
          n_chk++;
          if ({r1_ack, r0_ack} !== 2'b00) begin
            n_fail++;
            $display("FAIL rand_idle r=%0d c=%0d got=%b want=00",
                     r, c, {r1_ack, r0_ack});
          end
        end
      end
      if (k < nexp) begin
        n_chk++;
        n_fail++;
        $display("FAIL rand_timeout r=%0d acks=%0d want=%0d", r, k, nexp);
        do_reset();
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_init = 1'b0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    test_reset();
    test_write_read();
    test_simultaneous();
    test_misaligned();
    test_out_of_range();
    test_reset_access();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
